// File: rtl/modinv_helper_reduce_precalc_pkg.sv
// ---------------------------------------------------------------------------
// modinv_helper_reduce_precalc_pkg
//   Shared definitions for the word-serial modular-inverse helper stages:
//   word width, a constant-time clog2 and the processing-counter windows
//   that all helpers agree on.
// ---------------------------------------------------------------------------
package modinv_helper_reduce_precalc_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // Counter value at which word 0 is presented on the read port.
  localparam int CNT_READ_START  = 1;
  // Counter value at which word 0 is written (read start + read latency + add stage).
  localparam int CNT_WRITE_START = 3;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/modinv_helper_carry_adder32.sv
// ---------------------------------------------------------------------------
// modinv_helper_carry_adder32
//   32-bit adder with carry-in taken from its own registered carry-out, so
//   consecutive words form one long addition.
// Ports
//   clk, rst    clock, async active-high reset
//   i_ena       register sum/carry of the current word
//   i_clr       synchronous carry clear (start of a new operand)
//   i_a, i_b    addend words
//   o_sum_now   combinational sum of the current word (uses registered carry)
//   o_sum       registered sum word
//   o_carry     registered carry-out
// ---------------------------------------------------------------------------
module modinv_helper_carry_adder32
  import modinv_helper_reduce_precalc_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_ena,
  input  logic  i_clr,
  input  word_t i_a,
  input  word_t i_b,
  output word_t o_sum_now,
  output word_t o_sum,
  output logic  o_carry
);

  word_t           r_sum;
  logic            r_carry;
  logic [WORD_W:0] w_full;

  assign w_full    = {1'b0, i_a} + {1'b0, i_b} + {{WORD_W{1'b0}}, r_carry};
  assign o_sum_now = w_full[WORD_W-1:0];
  assign o_sum     = r_sum;
  assign o_carry   = r_carry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else if (i_clr) begin
      r_carry <= 1'b0;
    end else if (i_ena) begin
      {r_carry, r_sum} <= w_full;
    end
  end

endmodule

// File: rtl/modinv_helper_reduce_precalc.sv
// ---------------------------------------------------------------------------
// modinv_helper_reduce_precalc
//   Word-serial precalc stage of the binary modular inverter. Streams s and q
//   LSW-first and writes u = s >> 1 and v = (s + q) >> 1 (carry-out kept as
//   the MSB of v). o_s_is_odd tells the next stage which candidate to pick.
// Ports
//   clk, rst              clock, async active-high reset
//   i_ena / o_rdy         start pulse / idle flag
//   i_k_is_nul            suppress all buffer writes
//   o_s_is_odd            bit 0 of s word 0 of the latest pass
//   o_s_addr, o_q_addr    operand read address (1-cycle read latency)
//   i_s_din, i_q_din      operand read data
//   o_u_addr, o_v_addr    result write address
//   o_u_wren, o_v_wren    result write enable
//   o_u_dout, o_v_dout    result write data
// ---------------------------------------------------------------------------
module modinv_helper_reduce_precalc
  import modinv_helper_reduce_precalc_pkg::*;
#(
  parameter int BUFFER_NUM_WORDS = 9,
  parameter int BUFFER_ADDR_BITS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_ena,
  output logic                        o_rdy,
  input  logic                        i_k_is_nul,
  output logic                        o_s_is_odd,
  output logic [BUFFER_ADDR_BITS-1:0] o_s_addr,
  output logic [BUFFER_ADDR_BITS-1:0] o_q_addr,
  input  word_t                       i_s_din,
  input  word_t                       i_q_din,
  output logic [BUFFER_ADDR_BITS-1:0] o_u_addr,
  output logic [BUFFER_ADDR_BITS-1:0] o_v_addr,
  output logic                        o_u_wren,
  output logic                        o_v_wren,
  output word_t                       o_u_dout,
  output word_t                       o_v_dout
);

  localparam int N       = BUFFER_NUM_WORDS;
  localparam int CNT_MAX = N + 2;
  localparam int CNT_W   = clog2(N + 3);

  logic [CNT_W-1:0]            r_cnt;
  logic [BUFFER_ADDR_BITS-1:0] r_rd_addr;
  logic [BUFFER_ADDR_BITS-1:0] r_wr_addr;
  word_t                       r_s;
  logic                        r_s_is_odd;

  logic  w_rd_step;
  logic  w_add_en;
  logic  w_carry_clr;
  logic  w_win;
  logic  w_last;
  logic  w_wr_step;
  word_t w_sum_now;
  word_t w_sum;
  logic  w_carry;

  // Read address holds word i during cnt i+1, returning to 0 after the last word.
  assign w_rd_step   = (r_cnt >= CNT_W'(CNT_READ_START)) &&
                       (r_cnt <  CNT_W'(CNT_READ_START + N - 1));
  // Word i data is on the read bus during cnt i+2.
  assign w_add_en    = (r_cnt >= CNT_W'(CNT_READ_START + 1)) &&
                       (r_cnt <= CNT_W'(CNT_READ_START + N));
  assign w_carry_clr = (r_cnt == CNT_W'(CNT_READ_START));
  assign w_win       = (r_cnt >= CNT_W'(CNT_WRITE_START)) && (r_cnt <= CNT_W'(CNT_MAX));
  assign w_last      = (r_cnt == CNT_W'(CNT_MAX));
  assign w_wr_step   = w_win && !w_last;

  modinv_helper_carry_adder32 u_adder (
    .clk       (clk),
    .rst       (rst),
    .i_ena     (w_add_en),
    .i_clr     (w_carry_clr),
    .i_a       (i_s_din),
    .i_b       (i_q_din),
    .o_sum_now (w_sum_now),
    .o_sum     (w_sum),
    .o_carry   (w_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_rd_addr  <= '0;
      r_wr_addr  <= '0;
      r_s        <= '0;
      r_s_is_odd <= 1'b0;
    end else begin
      if (r_cnt == '0) begin
        if (i_ena) r_cnt <= CNT_W'(1);
      end else if (w_last) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      r_rd_addr <= w_rd_step ? r_rd_addr + 1'b1 : '0;
      r_wr_addr <= w_wr_step ? r_wr_addr + 1'b1 : '0;

      if (w_add_en) r_s <= i_s_din;
      if (r_cnt == CNT_W'(CNT_READ_START + 1)) r_s_is_odd <= i_s_din[0];
    end
  end

  assign o_rdy      = (r_cnt == '0);
  assign o_s_is_odd = r_s_is_odd;
  assign o_s_addr   = r_rd_addr;
  assign o_q_addr   = r_rd_addr;
  assign o_u_addr   = r_wr_addr;
  assign o_v_addr   = r_wr_addr;
  assign o_u_wren   = w_win && !i_k_is_nul;
  assign o_v_wren   = w_win && !i_k_is_nul;

  // Word w+1 is live on the read bus / adder output while word w is written,
  // so its low bit shifts into the top of word w. The last word takes 0 for u
  // and the final carry for v.
  assign o_u_dout = w_last ? {1'b0, r_s[WORD_W-1:1]}
                           : {i_s_din[0], r_s[WORD_W-1:1]};
  assign o_v_dout = w_last ? {w_carry, w_sum[WORD_W-1:1]}
                           : {w_sum_now[0], w_sum[WORD_W-1:1]};

endmodule

// File: tb/tb_modinv_helper_reduce_precalc.sv
module tb_modinv_helper_reduce_precalc;

  localparam int N = 9;
  localparam logic [31:0] SENT = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst;
  logic        ena;
  logic        rdy;
  logic        k_is_nul;
  logic        s_is_odd;
  logic [3:0]  s_addr, q_addr, u_addr, v_addr;
  logic [31:0] s_din, q_din, u_dout, v_dout;
  logic        u_wren, v_wren;

  logic [31:0] s_mem [0:15];
  logic [31:0] q_mem [0:15];
  logic [31:0] u_mem [0:15];
  logic [31:0] v_mem [0:15];
  logic [31:0] exp_u [0:N-1];
  logic [31:0] exp_v [0:N-1];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int ena_cyc = 0;
  int wr_cnt = 0;
  int first_off = -1;
  int last_off = -1;
  int inv_err = 0;
  logic clr_req = 1'b0;

  modinv_helper_reduce_precalc dut (
    .clk        (clk),
    .rst        (rst),
    .i_ena      (ena),
    .o_rdy      (rdy),
    .i_k_is_nul (k_is_nul),
    .o_s_is_odd (s_is_odd),
    .o_s_addr   (s_addr),
    .o_q_addr   (q_addr),
    .i_s_din    (s_din),
    .i_q_din    (q_din),
    .o_u_addr   (u_addr),
    .o_v_addr   (v_addr),
    .o_u_wren   (u_wren),
    .o_v_wren   (v_wren),
    .o_u_dout   (u_dout),
    .o_v_dout   (v_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    s_din <= s_mem[s_addr];
    q_din <= q_mem[q_addr];
  end

  always @(posedge clk) begin
    if (clr_req) begin
      for (int i = 0; i < 16; i++) begin
        u_mem[i] <= SENT;
        v_mem[i] <= SENT;
      end
      wr_cnt    <= 0;
      first_off <= -1;
      last_off  <= -1;
    end else begin
      if (u_wren) begin
        u_mem[u_addr] <= u_dout;
        wr_cnt        <= wr_cnt + 1;
        if (wr_cnt == 0) first_off <= cyc - ena_cyc;
        last_off <= cyc - ena_cyc;
      end
      if (v_wren) v_mem[v_addr] <= v_dout;
    end
  end

  always @(negedge clk) begin
    if (q_addr !== s_addr || v_addr !== u_addr || v_wren !== u_wren) inv_err <= inv_err + 1;
  end

  task automatic prep();
    @(negedge clk); clr_req = 1'b1;
    @(negedge clk); clr_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_mem[i] = '0;
      q_mem[i] = '0;
    end
  endtask

  task automatic start_pass();
    @(negedge clk); ena = 1'b1; ena_cyc = cyc;
    @(negedge clk); ena = 1'b0;
  endtask

  task automatic wait_rdy(output int lat);
    lat = 1;
    while (!rdy && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b0; k_is_nul = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_mem[i] = '0; q_mem[i] = '0;
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (rdy !== 1'b1 || s_is_odd !== 1'b0) begin
      n_err++; $display("FAIL reset_flags: rdy=%b s_is_odd=%b required rdy=1 s_is_odd=0", rdy, s_is_odd);
    end
    n_vec++;
    if (s_addr !== 4'd0 || u_addr !== 4'd0 || u_wren !== 1'b0) begin
      n_err++; $display("FAIL reset_outs: s_addr=%0d u_addr=%0d u_wren=%b required 0 0 0", s_addr, u_addr, u_wren);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    prep();
    s_mem[0] = 32'd6; q_mem[0] = 32'd7;
    start_pass();
    wait_rdy(lat);
    n_vec++;
    if (lat !== 12) begin n_err++; $display("FAIL basic_latency: got %0d required 12", lat); end
    n_vec++;
    if (wr_cnt !== 9 || first_off !== 3 || last_off !== 11) begin
      n_err++; $display("FAIL basic_window: writes=%0d first=%0d last=%0d required 9 3 11", wr_cnt, first_off, last_off);
    end
    for (int i = 0; i < N; i++) begin
      n_vec++;
      if (u_mem[i] !== ((i == 0) ? 32'd3 : 32'd0) || v_mem[i] !== ((i == 0) ? 32'd6 : 32'd0)) begin
        n_err++; $display("FAIL basic_word%0d: u=%h v=%h required u=%h v=%h", i, u_mem[i], v_mem[i],
                          (i == 0) ? 32'd3 : 32'd0, (i == 0) ? 32'd6 : 32'd0);
      end
    end
    n_vec++;
    if (s_is_odd !== 1'b0) begin n_err++; $display("FAIL basic_odd: got %b required 0", s_is_odd); end
  endtask

  task automatic test_all_ones();
    int lat;
    prep();
    for (int i = 0; i < N; i++) begin
      s_mem[i] = 32'hFFFF_FFFF; q_mem[i] = 32'hFFFF_FFFF;
      exp_u[i] = (i == N - 1) ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
      exp_v[i] = 32'hFFFF_FFFF;
    end
    start_pass();
    wait_rdy(lat);
    n_vec++;
    if (lat !== 12) begin n_err++; $display("FAIL ones_latency: got %0d required 12", lat); end
    for (int i = 0; i < N; i++) begin
      n_vec++;
      if (u_mem[i] !== exp_u[i] || v_mem[i] !== exp_v[i]) begin
        n_err++; $display("FAIL ones_word%0d: u=%h v=%h required u=%h v=%h", i, u_mem[i], v_mem[i], exp_u[i], exp_v[i]);
      end
    end
    n_vec++;
    if (s_is_odd !== 1'b1) begin n_err++; $display("FAIL ones_odd: got %b required 1", s_is_odd); end
  endtask

  task automatic test_word_shift();
    int lat;
    prep();
    s_mem[1] = 32'd1;
    start_pass();
    wait_rdy(lat);
    for (int i = 0; i < N; i++) begin
      n_vec++;
      if (u_mem[i] !== ((i == 0) ? 32'h8000_0000 : 32'd0) || v_mem[i] !== u_mem[i]) begin
        n_err++; $display("FAIL shift_word%0d: u=%h v=%h required %h", i, u_mem[i], v_mem[i],
                          (i == 0) ? 32'h8000_0000 : 32'd0);
      end
    end
    n_vec++;
    if (s_is_odd !== 1'b0) begin n_err++; $display("FAIL shift_odd: got %b required 0", s_is_odd); end
  endtask

  task automatic test_k_nul();
    int lat;
    prep();
    s_mem[0] = 32'd5; q_mem[0] = 32'd3;
    k_is_nul = 1'b1;
    start_pass();
    wait_rdy(lat);
    k_is_nul = 1'b0;
    n_vec++;
    if (lat !== 12) begin n_err++; $display("FAIL knul_latency: got %0d required 12", lat); end
    n_vec++;
    if (wr_cnt !== 0) begin n_err++; $display("FAIL knul_writes: got %0d required 0", wr_cnt); end
    n_vec++;
    if (u_mem[0] !== SENT || v_mem[0] !== SENT) begin
      n_err++; $display("FAIL knul_buf: u0=%h v0=%h required %h", u_mem[0], v_mem[0], SENT);
    end
    n_vec++;
    if (s_is_odd !== 1'b1) begin n_err++; $display("FAIL knul_odd: got %b required 1", s_is_odd); end
  endtask

  task automatic test_reset_mid();
    prep();
    start_pass();
    repeat (3) @(negedge clk);
    ena = 1'b1;
    @(negedge clk);
    ena = 1'b0;
    n_vec++;
    if (rdy !== 1'b0 || s_addr !== 4'd4 || u_addr !== 4'd2) begin
      n_err++; $display("FAIL mid_progress: rdy=%b s_addr=%0d u_addr=%0d required 0 4 2", rdy, s_addr, u_addr);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (rdy !== 1'b1 || s_addr !== 4'd0 || u_addr !== 4'd0 || u_wren !== 1'b0) begin
      n_err++; $display("FAIL mid_reset: rdy=%b s_addr=%0d u_addr=%0d u_wren=%b required 1 0 0 0",
                        rdy, s_addr, u_addr, u_wren);
    end
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (rdy !== 1'b1 || u_wren !== 1'b0) begin
      n_err++; $display("FAIL mid_idle: rdy=%b u_wren=%b required 1 0", rdy, u_wren);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    prep();
    for (int i = 0; i < N; i++) begin
      s_mem[i] = 32'hFFFF_FFFF; q_mem[i] = 32'hFFFF_FFFF;
    end
    @(negedge clk); ena = 1'b1; ena_cyc = cyc;
    repeat (11) @(negedge clk);
    n_vec++;
    if (rdy !== 1'b0) begin n_err++; $display("FAIL b2b_busy: rdy=%b required 0", rdy); end
    for (int i = 0; i < N; i++) begin
      s_mem[i] = (i == 0) ? 32'hFFFF_FFFF : 32'd0;
      q_mem[i] = 32'd0;
    end
    @(negedge clk);
    n_vec++;
    if (rdy !== 1'b1) begin n_err++; $display("FAIL b2b_gap: rdy=%b required 1", rdy); end
    @(negedge clk);
    n_vec++;
    if (rdy !== 1'b0) begin n_err++; $display("FAIL b2b_restart: rdy=%b required 0", rdy); end
    ena = 1'b0;
    wait_rdy(lat);
    n_vec++;
    if (lat !== 12 || wr_cnt !== 18 || last_off !== 23) begin
      n_err++; $display("FAIL b2b_timing: lat=%0d writes=%0d last=%0d required 12 18 23", lat, wr_cnt, last_off);
    end
    for (int i = 0; i < N; i++) begin
      n_vec++;
      if (u_mem[i] !== ((i == 0) ? 32'h7FFF_FFFF : 32'd0) || v_mem[i] !== u_mem[i]) begin
        n_err++; $display("FAIL b2b_word%0d: u=%h v=%h required %h", i, u_mem[i], v_mem[i],
                          (i == 0) ? 32'h7FFF_FFFF : 32'd0);
      end
    end
    n_vec++;
    if (s_is_odd !== 1'b1) begin n_err++; $display("FAIL b2b_odd: got %b required 1", s_is_odd); end
  endtask

  task automatic test_invariants();
    n_vec++;
    if (inv_err !== 0) begin
      n_err++; $display("FAIL addr_mirror: %0d cycles with q/s, v/u addr or wren differing, required 0", inv_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_ones();
    test_word_shift();
    test_k_nul();
    test_reset_mid();
    test_back_to_back();
    test_invariants();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
